fp_mul_arbiter: RTL

// - Shares one fpMul instance (AXI-stream single-precision multiplier) among NREQ requesters.
// - Round-robin issue of operand pairs; in-order tag FIFO routes each result back to its issuer.
// - Sits between compute clients and the fpMul instance; fpMul gets the same clock/rstn.

---
 rtl/fp_mul_arb_pkg.sv | 18 +
 rtl/fp_mul_tag_fifo.sv | 55 +++++
 rtl/fp_mul_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fp_mul_arb_pkg.sv
// Shared types and helpers for the fpMul round-robin arbiter.
// Tags are requester indices; at most eight requesters are supported.
package fp_mul_arb_pkg;

    localparam int FP_W     = 32;
    localparam int MAX_NREQ = 8;

    typedef logic [2:0] tag_t;

    function automatic int tag_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_NREQ-1:0] onehot(input tag_t idx);
        return MAX_NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/fp_mul_tag_fifo.sv
// In-order tag FIFO: remembers which requester issued each operation
// that is still inside the shared multiplier.
module fp_mul_tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 16
) (
    input  logic         clock,
    input  logic         rstn,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one AXI-stream fpMul among NREQ requesters.
// Define FP_MUL_ARB_STATS_EN to add per-requester delivered-result counters.
module fp_mul_arbiter
    import fp_mul_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int TAG_DEPTH = 16
) (
    input  logic                 clock,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*FP_W-1:0] req_a,
    input  logic [NREQ*FP_W-1:0] req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [FP_W-1:0]      rsp_data,
    output logic                 mul_a_tvalid,
    input  logic                 mul_a_tready,
    output logic [FP_W-1:0]      mul_a_tdata,
    output logic                 mul_b_tvalid,
    input  logic                 mul_b_tready,
    output logic [FP_W-1:0]      mul_b_tdata,
    input  logic                 mul_r_tvalid,
    output logic                 mul_r_tready,
    input  logic [FP_W-1:0]      mul_r_tdata,
`ifdef FP_MUL_ARB_STATS_EN
    output logic [NREQ*32-1:0]   stat_done,
`endif
    output logic                 err_orphan
);

    localparam int TAG_W = tag_w(NREQ);

    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [TAG_W-1:0] held_q, held_d;
    logic [TAG_W-1:0] grant_raw, grant, head;
    logic             hold_q, hold_d;
    logic             err_q, err_d;
    logic             found;
    logic             offer, issue_ok;
    logic             fifo_full, fifo_empty;
    logic             rsp_on, rsp_fire;

    always_comb begin
        int idx;
        found     = 1'b0;
        grant_raw = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_raw = TAG_W'(idx);
            end
        end
    end

    // An offered but unaccepted pair must not change under the multiplier.
    assign grant    = hold_q ? held_q : grant_raw;
    assign offer    = rstn & (|req_valid) & ~fifo_full;
    assign issue_ok = offer & mul_a_tready & mul_b_tready;

    assign mul_a_tvalid = offer;
    assign mul_b_tvalid = offer;
    assign mul_a_tdata  = req_a[FP_W*grant +: FP_W];
    assign mul_b_tdata  = req_b[FP_W*grant +: FP_W];
    assign req_ready    = NREQ'(onehot(tag_t'(grant))) & {NREQ{issue_ok}};

    assign rsp_on       = rstn & mul_r_tvalid & ~fifo_empty;
    assign rsp_fire     = rsp_on & rsp_ready[head];
    assign rsp_valid    = rsp_on ? NREQ'(onehot(tag_t'(head))) : '0;
    assign rsp_data     = mul_r_tdata;
    // An empty FIFO drains stray results so the multiplier never wedges.
    assign mul_r_tready = rstn & (fifo_empty | rsp_ready[head]);
    assign err_orphan   = err_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (issue_ok) begin
            rr_ptr_d = (grant == TAG_W'(NREQ - 1)) ? '0 : grant + 1'b1;
        end
        hold_d = offer & ~issue_ok;
        held_d = grant;
        err_d  = err_q | (mul_r_tvalid & fifo_empty);
    end

    always_ff @(posedge clock) begin
        if (!rstn) begin
            rr_ptr_q <= '0;
            hold_q   <= 1'b0;
            held_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
            held_q   <= held_d;
            err_q    <= err_d;
        end
    end

    fp_mul_tag_fifo #(
        .W     (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .rstn    (rstn),
        .push_i  (issue_ok),
        .pop_i   (rsp_fire),
        .wdata_i (grant),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef FP_MUL_ARB_STATS_EN
    logic [31:0] cnt_q [NREQ];
    logic [31:0] cnt_d [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (rsp_fire && head == TAG_W'(i)) begin
                cnt_d[i] = cnt_q[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NREQ; i++) begin
            cnt_q[i] <= rstn ? cnt_d[i] : 32'd0;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        assign stat_done[32*g +: 32] = cnt_q[g];
    end
`endif

endmodule
